// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage and its neighbours
// (immediate generator, decoder):
//   - XLEN and the fetch FSM state enum
//   - canonical NOP encoding and RV32I major opcodes
//   - fetch buffer entry layout {inst, pc}
//   - word_align(): clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // RV32I major opcodes shared with the immediate generator and decoder.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // One fetch buffer entry: 64 bits, instruction in the upper half.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small circular fetch buffer holding {inst, pc} entries for decode.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push, push_data      write one entry at the tail
//   pop                  retire the head (caller guarantees head_valid)
//   flush                drop all entries; wins over a same-cycle push
//   count                number of stored entries (0..DEPTH)
//   head_valid, head_data  registered head entry, all-zero when empty
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; stale contents are never
  // visible because the head is qualified by count_q, which is reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Fetch stage feeding the immediate generator / decoder. Keeps the PC, issues
// one outstanding word request at a time and buffers returned words.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req/imem_addr            request and word address (= pc)
//   imem_gnt                      request accepted this cycle
//   imem_rvalid/imem_rdata        returned instruction word
//   redirect_valid/redirect_pc    one-cycle restart pulse and target
//   id_valid/id_ready             handshake towards decode
//   id_inst/id_pc                 head instruction and its PC (zero when idle)
// -----------------------------------------------------------------------------
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_WAIT = 2'(WAIT);
  localparam logic [1:0] S_DROP = 2'(DROP);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  // Holds the request low for the first cycle after reset release so that
  // imem_req is 0 throughout reset, not just after it.
  logic            started_q, started_d;

  logic            fifo_push;
  logic            fifo_pop;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_in;
  fetch_entry_t    fifo_head;

  // A redirect suppresses issue: the address would belong to the stale stream.
  assign imem_req  = started_q && (state_q == S_IDLE) &&
                     (fifo_count < DEPTH_CNT) && !redirect_valid;
  assign imem_addr = pc_q;

  assign fifo_in  = '{inst: imem_rdata, pc: req_pc_q};
  assign fifo_pop = id_valid && id_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    started_d = 1'b1;
    fifo_push = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A response seen here is a stray from before reset and is ignored.
        if (imem_req && imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          fifo_push = !redirect_valid;
          state_d   = S_IDLE;
        end else if (redirect_valid) begin
          // The response is still owed; swallow it before issuing again.
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) pc_d = word_align(redirect_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= word_align(RESET_PC);
      req_pc_q  <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      started_q <= started_d;
    end
  end

  // Redirect flushes the buffer at the same edge that honours a pending pop.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (fifo_in),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .count      (fifo_count),
    .head_valid (id_valid),
    .head_data  (fifo_head)
  );

  assign id_inst = fifo_head.inst;
  assign id_pc   = fifo_head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Drives inst_fetch_unit with a behavioural instruction memory (random grant,
// random response delay, stray responses) and a random decode/redirect
// environment. Expected decode traffic is an in-order queue of {inst, pc}
// words fetched since the last redirect; the fetch address is a running
// sequential PC that jumps on redirect.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int          DEPTH  = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  inst_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Instruction memory image: explicit words for directed tests, a hash elsewhere.
  logic [31:0] img [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (img.exists(a)) return img[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  // Reference model state.
  ent_t        q[$];
  logic        pend;
  logic        pend_drop;
  logic [31:0] pend_addr;
  int          pend_dly;
  logic [31:0] exp_pc;

  // Per-cycle stimulus.
  logic        drv_gnt, drv_redir, drv_ready, drv_stray;
  logic [31:0] drv_rpc, drv_stray_data;
  int          drv_dly;

  // Values sampled in the most recent cycle.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic model_reset();
    q.delete();
    pend      = 1'b0;
    pend_drop = 1'b0;
    pend_addr = '0;
    pend_dly  = 0;
    exp_pc    = RST_PC;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    #1;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_inst",  id_inst, 32'd0);
    check("rst_pc",    id_pc,   32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("req_at_release", 32'(imem_req), 32'd0);
    @(posedge clk);
  endtask

  task automatic run_cycle();
    logic rv;
    logic exp_req, exp_valid;
    @(negedge clk);
    rv             = (pend && pend_dly == 0) || (drv_stray && !pend);
    imem_rvalid    = rv;
    imem_rdata     = pend ? mem_word(pend_addr) : drv_stray_data;
    imem_gnt       = drv_gnt;
    redirect_valid = drv_redir;
    redirect_pc    = drv_rpc;
    id_ready       = drv_ready;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = id_valid;
    s_inst  = id_inst;
    s_pc    = id_pc;

    exp_req   = !pend && (q.size() < DEPTH) && !drv_redir;
    exp_valid = (q.size() != 0);
    check("imem_req", 32'(s_req), 32'(exp_req));
    if (exp_req) check("imem_addr", s_addr, exp_pc);
    check("id_valid", 32'(s_valid), 32'(exp_valid));
    check("id_inst", s_inst, exp_valid ? q[0].inst : 32'd0);
    check("id_pc",   s_pc,   exp_valid ? q[0].pc   : 32'd0);
    if (dut.fifo_push)
      check("no_push_full",
            32'(!dut.fifo_pop && (int'(dut.fifo_count) == DEPTH)), 32'd0);

    // Effects of the coming clock edge.
    if (exp_valid && drv_ready) void'(q.pop_front());
    if (pend && pend_dly == 0) begin
      if (!drv_redir && !pend_drop)
        q.push_back('{inst: mem_word(pend_addr), pc: pend_addr});
      pend = 1'b0;
    end else if (pend) begin
      pend_dly--;
    end
    if (exp_req && drv_gnt) begin
      pend      = 1'b1;
      pend_drop = 1'b0;
      pend_addr = exp_pc;
      pend_dly  = drv_dly;
      exp_pc    = exp_pc + 32'd4;
    end
    if (drv_redir) begin
      q.delete();
      exp_pc = drv_rpc & ~32'h0000_0003;
      if (pend) pend_drop = 1'b1;
    end
  endtask

  task automatic cyc(input logic g, input logic r, input logic [31:0] rpc,
                     input logic rdy, input int dly);
    drv_gnt   = g;
    drv_redir = r;
    drv_rpc   = rpc;
    drv_ready = rdy;
    drv_dly   = dly;
    run_cycle();
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    drv_stray      = 1'b0;
    drv_stray_data = '0;
    model_reset();

    // First fetch after reset and its two-cycle latency to decode.
    img[32'h1000] = 32'h0050_0093;
    do_reset();
    cyc(1, 0, 0, 0, 0);
    check("t1_req",  32'(s_req), 32'd1);
    check("t1_addr", s_addr, 32'h0000_1000);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("t1_valid", 32'(s_valid), 32'd1);
    check("t1_inst",  s_inst, 32'h0050_0093);
    check("t1_pc",    s_pc,   32'h0000_1000);

    // Backpressure fills the buffer and stalls issue.
    img[32'h1000] = 32'h0000_000A;
    img[32'h1004] = 32'h0000_000B;
    img[32'h1008] = 32'hDEAD_BEEF;
    do_reset();
    repeat (4) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("t2_stall_req",  32'(s_req), 32'd0);
    check("t2_stall_addr", s_addr, 32'h0000_1008);
    cyc(1, 0, 0, 0, 0);
    check("t2_stall_req2", 32'(s_req), 32'd0);
    cyc(1, 0, 0, 1, 0);
    check("t2_pop_a_inst", s_inst, 32'h0000_000A);
    check("t2_pop_a_pc",   s_pc,   32'h0000_1000);
    cyc(1, 0, 0, 1, 2);
    check("t2_pop_b_inst", s_inst, 32'h0000_000B);
    check("t2_pop_b_pc",   s_pc,   32'h0000_1004);
    check("t2_resume_req", 32'(s_req), 32'd1);
    check("t2_resume_addr", s_addr, 32'h0000_1008);

    // Redirect while waiting; the late response is discarded.
    cyc(0, 1, 32'h0000_2003, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("t3_valid", 32'(s_valid), 32'd0);
    check("t3_addr",  s_addr, 32'h0000_2000);

    // Redirect coinciding with a response while one entry is buffered.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("t4_one_entry", 32'(s_valid), 32'd1);
    cyc(0, 1, 32'h0000_3000, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("t4_valid", 32'(s_valid), 32'd0);
    check("t4_req",   32'(s_req), 32'd1);
    check("t4_addr",  s_addr, 32'h0000_3000);

    // PC wraps modulo 2^32.
    cyc(0, 1, 32'hFFFF_FFFC, 1, 0);
    cyc(1, 0, 0, 1, 0);
    check("t5_addr0", s_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    check("t5_addr1", s_addr, 32'h0000_0000);
    check("t5_pc0",   s_pc,   32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("t5_pc1",   s_pc,   32'h0000_0000);

    // Reset while waiting, then a stray response after release.
    cyc(1, 0, 0, 1, 3);
    cyc(0, 0, 0, 1, 0);
    do_reset();
    drv_stray      = 1'b1;
    drv_stray_data = 32'h1234_5678;
    cyc(0, 0, 0, 1, 0);
    drv_stray = 1'b0;
    check("t6_addr", s_addr, RST_PC);
    cyc(0, 0, 0, 1, 0);
    check("t6_valid", 32'(s_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drv_stray      = !pend && ($urandom_range(0, 29) == 0);
      drv_stray_data = $urandom;
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 19) == 0),
          $urandom,
          ($urandom_range(0, 9) < 6),
          int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the immediate generator and decoder.
- Holds the PC and issues one-outstanding word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents {instruction, PC} to decode with valid/ready.
- id_inst drives the immediate generator's 32-bit instruction input; redirects (taken branch target = PC + B-imm) flush stale work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, fetch buffer entries; legal values 2 or 4.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
imem_req  output  1  fetch request; address held stable until granted.
imem_addr  output  32  word address of request (= pc).
imem_gnt  input  1  memory accepts request this cycle when imem_req=1.
imem_rvalid  input  1  read data valid; earliest the cycle after grant.
imem_rdata  input  32  instruction word.
redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc.
redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 00).
id_valid  output  1  FIFO head valid.
id_ready  input  1  decode accepts head this cycle.
id_inst  output  32  head instruction; 32'h0 when id_valid=0.
id_pc  output  32  head PC; 32'h0 when id_valid=0.

Behaviour:
- Reset (async, while rst_n=0):
  - pc=RESET_PC, state=IDLE, FIFO empty.
  - imem_req=0, id_valid=0, id_inst=0, id_pc=0.
- FSM states: IDLE, WAIT, DROP.
  - IDLE: imem_req = (count<FIFO_DEPTH) && !redirect_valid. On imem_gnt: latch pc as req_pc, pc<=pc+4, go to WAIT.
  - WAIT: imem_req=0.
    - rvalid && !redirect: push {imem_rdata, req_pc}, go to IDLE.
    - rvalid && redirect: drop the data, go to IDLE.
    - !rvalid && redirect: go to DROP.
  - DROP: imem_req=0. On rvalid, discard the data and go to IDLE. A redirect in DROP only reloads pc.
- imem_rvalid in IDLE is ignored (stray response after reset).
- Redirect, in any state:
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO cleared at the same edge; id_valid=0 from the next cycle.
  - A pop in the redirect cycle is still honoured: decode sees the handshake, then the flush.
  - Redirect overrides a same-cycle push.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- FIFO:
  - Push on accepted rvalid (see WAIT); pop when id_valid && id_ready.
  - Push and pop in the same cycle keeps count.
  - Overflow is impossible: issue requires count<FIFO_DEPTH, with at most one outstanding request.
  - The bench asserts no push when full.
- Latency:
  - grant at cycle N, rvalid at N+1 → id_valid at N+2.
  - Peak throughput is one instruction per 2 cycles (no issue in WAIT).
- Outputs id_* are registered FIFO-head values (no combinational path from imem_rdata).
- imem_req/imem_addr depend only on state, count and redirect_valid.

Decomposition:
- fetch_pkg:
  - XLEN=32 and the fetch_state_e enum {IDLE, WAIT, DROP}.
  - NOP=32'h0000_0013.
  - RV32I opcode constants (LOAD 7'b0000011, OP_IMM 7'b0010011, BRANCH 7'b1100011, LUI 7'b0110111), shared with the immediate generator and decoder.
- One sub-module, fetch_fifo:
  - parameterised depth, 64-bit entries {inst, pc}.
  - push/pop/flush, count, head outputs.

Test Plan:
1. RESET_PC=32'h0000_1000; release rst_n → next cycle imem_req=1, imem_addr=0x1000. gnt at N, rvalid at N+1 with 0x00500093 → at N+2 id_valid=1, id_inst=0x00500093, id_pc=0x1000.
2. Backpressure: id_ready=0, memory returns 0xA/0xB for 0x1000/0x1004 → after 2 fetches imem_req stays 0 with imem_addr=0x1008. Raise id_ready → pops 0xA@0x1000 then 0xB@0x1004, then the request for 0x1008 resumes.
3. Redirect in WAIT to 0x2003: rvalid two cycles later with 0xDEAD_BEEF → data discarded, FIFO empty, next imem_addr=0x2000.
4. Redirect and rvalid in the same cycle, one entry in FIFO → FIFO empty next cycle, response dropped, state IDLE, next request at redirect address.
5. Redirect to 0xFFFF_FFFC, two fetches → imem_addr sequence 0xFFFF_FFFC, 0x0000_0000; id_pc values match.
6. Assert rst_n=0 mid-WAIT → outputs zero immediately (async). After release, a late stray rvalid with 0x1234_5678 → ignored, id_valid stays 0, fetch restarts at RESET_PC.
